// File: rtl/run_monitor.sv
// run_monitor: run supervisor for the CPU core. Watches io_pc/io_out/io_exit,
// produces a sticky verdict with failure cause, a saturating RUN cycle count
// and a readable ring-buffer trace of {pc, acc} history.
// Optional simulation printing is enabled by defining RUN_MON_PRINT_EN.
module run_monitor #(
  parameter int PC_W        = 8,
  parameter int ACC_W       = 16,
  parameter int TRACE_DEPTH = 16,
  parameter int TIMEOUT_CYC = 4096,
  parameter int STALL_LIM   = 64,
  parameter int PASS_VAL    = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             clr,
  input  logic [PC_W-1:0]                  io_pc,
  input  logic [ACC_W-1:0]                 io_out,
  input  logic                             io_exit,
  input  logic [$clog2(TRACE_DEPTH)-1:0]   rd_idx,
  output logic [PC_W+ACC_W-1:0]            rd_data,
  output logic [$clog2(TRACE_DEPTH):0]     trace_cnt,
  output logic [31:0]                      cycle_cnt,
  output logic                             busy,
  output logic                             done,
  output logic                             pass,
  output logic [1:0]                       fail_code
);

  localparam int PTR_W = $clog2(TRACE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = $clog2(STALL_LIM) + 1;
  localparam int ENT_W = PC_W + ACC_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] FC_NONE  = 2'd0;
  localparam logic [1:0] FC_ACC   = 2'd1;
  localparam logic [1:0] FC_STALL = 2'd2;
  localparam logic [1:0] FC_TMO   = 2'd3;

  logic [1:0]       r_state;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_trace_cnt;
  logic [31:0]      r_cycle_cnt;
  logic [ST_W-1:0]  r_stall_cnt;
  logic [PC_W-1:0]  r_last_pc;
  logic             r_done;
  logic             r_pass;
  logic [1:0]       r_fail_code;
  logic [ENT_W-1:0] r_rd_data;
  logic [ENT_W-1:0] r_mem [TRACE_DEPTH];

  logic             w_pc_chg;
  logic [31:0]      w_cyc_next;
  logic [ST_W-1:0]  w_stall_next;
  logic             w_acc_ok;
  logic             w_stall_hit;
  logic             w_tmo_hit;
  logic             w_wr_en;
  logic [PTR_W-1:0] w_rd_addr;
  logic             w_rd_ok;

  assign w_pc_chg     = (io_pc != r_last_pc);
  assign w_cyc_next   = (r_cycle_cnt == 32'hFFFF_FFFF) ? r_cycle_cnt : r_cycle_cnt + 32'd1;
  assign w_stall_next = r_stall_cnt + ST_W'(1);
  assign w_acc_ok     = (io_out == ACC_W'(PASS_VAL));
  // A stall needs the PC to still be unchanged on the cycle the limit is hit.
  assign w_stall_hit  = !w_pc_chg && (w_stall_next >= ST_W'(STALL_LIM - 1));
  assign w_tmo_hit    = (w_cyc_next >= 32'(TIMEOUT_CYC));
  // Entry cycle always traces; later RUN cycles trace only on a PC change.
  assign w_wr_en      = !clr && (((r_state == S_IDLE) && en) ||
                                 ((r_state == S_RUN) && w_pc_chg));
  // Index 0 maps to the oldest valid entry; a full ring makes this wr_ptr.
  assign w_rd_addr    = r_wr_ptr - r_trace_cnt[PTR_W-1:0] + rd_idx;
  assign w_rd_ok      = ({1'b0, rd_idx} < r_trace_cnt);

  assign rd_data   = r_rd_data;
  assign trace_cnt = r_trace_cnt;
  assign cycle_cnt = r_cycle_cnt;
  assign busy      = (r_state == S_RUN);
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail_code = r_fail_code;

  // Trace storage: no reset so it maps onto RAM; validity comes from trace_cnt.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= {io_pc, io_out};
  end

  // Registered read port; a same-edge write to the slot returns the old entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_rd_data <= '0;
    else if (clr)  r_rd_data <= '0;
    else           r_rd_data <= w_rd_ok ? r_mem[w_rd_addr] : '0;
  end

  // Control FSM, counters, trace pointers and sticky verdict.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_trace_cnt <= '0;
      r_cycle_cnt <= '0;
      r_stall_cnt <= '0;
      r_last_pc   <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_code <= FC_NONE;
    end else if (clr) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_trace_cnt <= '0;
      r_cycle_cnt <= '0;
      r_stall_cnt <= '0;
      r_last_pc   <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_code <= FC_NONE;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (r_trace_cnt != CNT_W'(TRACE_DEPTH)) r_trace_cnt <= r_trace_cnt + CNT_W'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_state     <= S_RUN;
            r_last_pc   <= io_pc;
            r_stall_cnt <= '0;
            r_cycle_cnt <= 32'd1;
          end
        end
        S_RUN: begin
          r_cycle_cnt <= w_cyc_next;
          if (w_pc_chg) begin
            r_last_pc   <= io_pc;
            r_stall_cnt <= '0;
          end else begin
            r_stall_cnt <= w_stall_next;
          end
          if (io_exit) begin
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_pass      <= w_acc_ok;
            r_fail_code <= w_acc_ok ? FC_NONE : FC_ACC;
          end else if (w_stall_hit) begin
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_pass      <= 1'b0;
            r_fail_code <= FC_STALL;
          end else if (w_tmo_hit) begin
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_pass      <= 1'b0;
            r_fail_code <= FC_TMO;
          end
        end
        default: ; // DONE (and any unused code) holds until clr or reset
      endcase
    end
  end

`ifdef RUN_MON_PRINT_EN
  // Simulation-only trace and verdict printing.
  always @(posedge clk) begin
    if (rst && w_wr_en) $display("pc=%h acc=%h", io_pc, io_out);
    if (rst && !clr && (r_state == S_RUN)) begin
      if (io_exit)
        $display("run_monitor %s fail_code=%0d", w_acc_ok ? "PASSED" : "FAILED",
                 w_acc_ok ? FC_NONE : FC_ACC);
      else if (w_stall_hit)
        $display("run_monitor FAILED fail_code=%0d", FC_STALL);
      else if (w_tmo_hit)
        $display("run_monitor FAILED fail_code=%0d", FC_TMO);
    end
  end
  final $display("run_monitor cycle_cnt=%0d", r_cycle_cnt);
`else
`endif

endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: directed and randomized checks of run_monitor against a
// queue-based behavioural model of the run supervisor.
module tb_run_monitor;

  localparam int PC_W        = 8;
  localparam int ACC_W       = 16;
  localparam int TRACE_DEPTH = 16;
  localparam int TIMEOUT_CYC = 100;
  localparam int STALL_LIM   = 64;
  localparam int PASS_VAL    = 0;

  logic        clk;
  logic        rst;
  logic        en;
  logic        clr;
  logic [7:0]  io_pc;
  logic [15:0] io_out;
  logic        io_exit;
  logic [3:0]  rd_idx;
  logic [23:0] rd_data;
  logic [4:0]  trace_cnt;
  logic [31:0] cycle_cnt;
  logic        busy;
  logic        done;
  logic        pass;
  logic [1:0]  fail_code;

  run_monitor #(
    .PC_W(PC_W), .ACC_W(ACC_W), .TRACE_DEPTH(TRACE_DEPTH),
    .TIMEOUT_CYC(TIMEOUT_CYC), .STALL_LIM(STALL_LIM), .PASS_VAL(PASS_VAL)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .io_pc(io_pc), .io_out(io_out), .io_exit(io_exit),
    .rd_idx(rd_idx), .rd_data(rd_data), .trace_cnt(trace_cnt),
    .cycle_cnt(cycle_cnt), .busy(busy), .done(done), .pass(pass),
    .fail_code(fail_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model: phase 0 idle, 1 running, 2 finished.
  int          m_phase;
  int          m_cyc;
  int          m_same;
  logic [7:0]  m_last;
  logic        m_pass;
  logic [1:0]  m_code;
  logic [23:0] m_trace[$];

  logic [7:0]  cur_pc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_phase = 0; m_cyc = 0; m_same = 0; m_last = '0;
    m_pass = 1'b0; m_code = 2'd0;
    m_trace.delete();
  endtask

  function automatic logic [23:0] model_read(input logic [3:0] idx);
    if (int'(idx) < m_trace.size()) return m_trace[idx];
    return 24'h0;
  endfunction

  task automatic model_push(input logic [7:0] p, input logic [15:0] a);
    m_trace.push_back({p, a});
    if (m_trace.size() > TRACE_DEPTH) void'(m_trace.pop_front());
  endtask

  task automatic model_edge(input logic e, input logic c, input logic [7:0] p,
                            input logic [15:0] a, input logic x);
    if (c) model_reset();
    else if (m_phase == 0) begin
      if (e) begin
        m_phase = 1; model_push(p, a); m_last = p; m_same = 1; m_cyc = 1;
      end
    end else if (m_phase == 1) begin
      m_cyc++;
      if (p != m_last) begin model_push(p, a); m_last = p; m_same = 1; end
      else m_same++;
      if (x) begin
        m_phase = 2; m_pass = (a == PASS_VAL); m_code = m_pass ? 2'd0 : 2'd1;
      end else if (m_same >= STALL_LIM) begin
        m_phase = 2; m_pass = 1'b0; m_code = 2'd2;
      end else if (m_cyc >= TIMEOUT_CYC) begin
        m_phase = 2; m_pass = 1'b0; m_code = 2'd3;
      end
    end
  endtask

  task automatic check_all(input logic [23:0] exp_rd);
    chk("busy",      busy,      (m_phase == 1));
    chk("done",      done,      (m_phase == 2));
    chk("pass",      pass,      m_pass);
    chk("fail_code", fail_code, m_code);
    chk("cycle_cnt", cycle_cnt, m_cyc);
    chk("trace_cnt", trace_cnt, m_trace.size());
    chk("rd_data",   rd_data,   exp_rd);
  endtask

  // One clock: drive at the falling edge, model the rising edge, check at the next falling edge.
  task automatic step(input logic e, input logic c, input logic [7:0] p,
                      input logic [15:0] a, input logic x, input logic [3:0] idx);
    logic [23:0] exp_rd;
    en = e; clr = c; io_pc = p; io_out = a; io_exit = x; rd_idx = idx;
    exp_rd = c ? 24'h0 : model_read(idx);
    @(posedge clk);
    model_edge(e, c, p, a, x);
    @(negedge clk);
    check_all(exp_rd);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst = 1'b0; en = 1'b0; clr = 1'b0; io_pc = '0; io_out = '0; io_exit = 1'b0; rd_idx = '0;
    #1;
    check_all(24'h0);
    @(negedge clk);
    rst = 1'b1;

    // Idle with en low: nothing moves.
    step(1'b0, 1'b0, 8'h33, 16'h1234, 1'b0, 4'd0);

    // Run 1: PC 0..5, exit with acc=0 on PC 5.
    step(1'b1, 1'b0, 8'd0, 16'($urandom), 1'b0, 4'd0);
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 8'(i), 16'($urandom), 1'b0, 4'($urandom));
    step(1'b0, 1'b0, 8'd5, 16'h0000, 1'b1, 4'd0);
    chk("t1_done", done, 1'b1);
    chk("t1_pass", pass, 1'b1);
    chk("t1_code", fail_code, 2'd0);
    chk("t1_cyc", cycle_cnt, 32'd6);
    chk("t1_tcnt", trace_cnt, 5'd6);
    step(1'b0, 1'b0, 8'd5, 16'h0, 1'b0, 4'd0);
    chk("t1_rd0_pc", rd_data[23:16], 8'h00);
    step(1'b0, 1'b0, 8'd5, 16'h0, 1'b0, 4'd9);
    chk("t1_rd_oob", rd_data, 24'h0);
    // en during DONE is ignored.
    step(1'b1, 1'b0, 8'd7, 16'h0, 1'b0, 4'd5);
    chk("t1_hold_cyc", cycle_cnt, 32'd6);
    chk("t1_hold_busy", busy, 1'b0);
    chk("t1_rd5_pc", rd_data[23:16], 8'h05);
    step(1'b0, 1'b1, 8'd0, 16'h0, 1'b0, 4'd0);
    chk("clr_done", done, 1'b0);
    chk("clr_tcnt", trace_cnt, 5'd0);

    // Run 2: same sequence, wrong accumulator at exit.
    step(1'b1, 1'b0, 8'd0, 16'($urandom), 1'b0, 4'd0);
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 8'(i), 16'($urandom), 1'b0, 4'd0);
    step(1'b0, 1'b0, 8'd5, 16'h0012, 1'b1, 4'd0);
    chk("t2_pass", pass, 1'b0);
    chk("t2_code", fail_code, 2'd1);
    step(1'b0, 1'b1, 8'd0, 16'h0, 1'b0, 4'd0);

    // Run 3: PC stuck at 0x20 for 64 cycles -> stall.
    step(1'b1, 1'b0, 8'h20, 16'($urandom), 1'b0, 4'd0);
    for (int i = 2; i <= 63; i++) step(1'b0, 1'b0, 8'h20, 16'($urandom), 1'b0, 4'd0);
    chk("t3_not_yet", done, 1'b0);
    step(1'b0, 1'b0, 8'h20, 16'($urandom), 1'b0, 4'd0);
    chk("t3_done", done, 1'b1);
    chk("t3_code", fail_code, 2'd2);
    chk("t3_tcnt", trace_cnt, 5'd1);
    step(1'b0, 1'b1, 8'd0, 16'h0, 1'b0, 4'd0);

    // Run 4: stall cycle coincides with exit -> exit verdict wins.
    step(1'b1, 1'b0, 8'h20, 16'($urandom), 1'b0, 4'd0);
    for (int i = 2; i <= 63; i++) step(1'b0, 1'b0, 8'h20, 16'($urandom), 1'b0, 4'd0);
    step(1'b0, 1'b0, 8'h20, 16'h0005, 1'b1, 4'd0);
    chk("t4_code", fail_code, 2'd1);
    chk("t4_pass", pass, 1'b0);
    step(1'b0, 1'b1, 8'd0, 16'h0, 1'b0, 4'd0);

    // Run 5: PC increments forever -> timeout at cycle 100.
    cur_pc = 8'd0;
    step(1'b1, 1'b0, cur_pc, 16'($urandom), 1'b0, 4'd0);
    for (int i = 0; i < 200 && m_phase == 1; i++) begin
      cur_pc = cur_pc + 8'd1;
      step(1'b0, 1'b0, cur_pc, 16'($urandom), 1'b0, 4'($urandom));
    end
    chk("t5_done", done, 1'b1);
    chk("t5_code", fail_code, 2'd3);
    chk("t5_cyc", cycle_cnt, 32'd100);
    chk("t5_tcnt", trace_cnt, 5'd16);
    step(1'b0, 1'b0, cur_pc, 16'h0, 1'b0, 4'd0);
    chk("t5_rd0_pc", rd_data[23:16], 8'd84);
    step(1'b0, 1'b1, 8'd0, 16'h0, 1'b0, 4'd0);

    // Run 6: 40 distinct PCs, exit with pass on the 40th -> ring overflow.
    step(1'b1, 1'b0, 8'd0, 16'($urandom), 1'b0, 4'd0);
    for (int i = 1; i <= 38; i++) step(1'b0, 1'b0, 8'(i), 16'($urandom), 1'b0, 4'($urandom));
    step(1'b0, 1'b0, 8'd39, 16'h0000, 1'b1, 4'd0);
    chk("t6_pass", pass, 1'b1);
    chk("t6_tcnt", trace_cnt, 5'd16);
    step(1'b0, 1'b0, 8'd39, 16'h0, 1'b0, 4'd0);
    chk("t6_rd0_pc", rd_data[23:16], 8'd24);
    step(1'b0, 1'b0, 8'd39, 16'h0, 1'b0, 4'd15);
    chk("t6_rd15_pc", rd_data[23:16], 8'd39);
    step(1'b0, 1'b1, 8'd0, 16'h0, 1'b0, 4'd0);

    // Run 7: asynchronous reset at cycle 10, then a fresh run.
    step(1'b1, 1'b0, 8'd0, 16'($urandom), 1'b0, 4'd0);
    for (int i = 1; i <= 9; i++) step(1'b0, 1'b0, 8'(i), 16'($urandom), 1'b0, 4'd0);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check_all(24'h0);
    @(negedge clk);
    @(negedge clk);
    check_all(24'h0);
    rst = 1'b1;
    step(1'b1, 1'b0, 8'h40, 16'($urandom), 1'b0, 4'd0);
    chk("t7_cyc1", cycle_cnt, 32'd1);
    chk("t7_busy", busy, 1'b1);
    step(1'b0, 1'b1, 8'd0, 16'h0, 1'b0, 4'd0);

    // Randomized runs: random PC holds/jumps, random exits and read indices.
    for (int r = 0; r < 10; r++) begin
      cur_pc = 8'($urandom);
      step(1'b1, 1'b0, cur_pc, 16'($urandom), 1'b0, 4'($urandom));
      for (int i = 0; i < 150 && m_phase == 1; i++) begin
        logic x;
        logic [15:0] a;
        if ($urandom_range(0, 1) == 1) cur_pc = 8'($urandom);
        x = ($urandom_range(0, 39) == 0);
        a = (x && $urandom_range(0, 1) == 1) ? 16'h0000 : 16'($urandom);
        step(1'b0, 1'b0, cur_pc, a, x, 4'($urandom));
      end
      chk("rand_finished", done, 1'b1);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, cur_pc, 16'($urandom), 1'b0, 4'($urandom));
      step(1'b0, 1'b1, 8'd0, 16'h0, 1'b0, 4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/run_monitor.md
Name: run_monitor

Overview:
Parametrised run supervisor for the CPU core. Sits beside CpuID and watches io_pc, io_out and io_exit. Produces a sticky pass/fail verdict with a failure cause, a saturating cycle count and a ring-buffer trace of PC/accumulator history that can be read back. Replaces the fixed-width, exit-only checking with timeout and stall detection, and is synthesizable so the same checks run in simulation and on FPGA.

Parameters:
PC_W, 8, width of io_pc
ACC_W, 16, width of io_out (accumulator)
TRACE_DEPTH, 16, trace entries; power of 2, >= 2
TIMEOUT_CYC, 4096, RUN cycles before TIMEOUT fail; >= 1
STALL_LIM, 64, consecutive RUN cycles with unchanged io_pc that trigger STALL fail; >= 2
PASS_VAL, 0, accumulator value required at exit for a pass

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  start monitoring; sampled in IDLE
clr  in  1  synchronous clear back to IDLE; clears the verdict, counters and trace
io_pc  in  PC_W  CPU program counter
io_out  in  ACC_W  CPU accumulator
io_exit  in  1  CPU exit strobe
rd_idx  in  $clog2(TRACE_DEPTH)  trace read index; 0 = oldest valid entry
rd_data  out  PC_W+ACC_W  {pc, acc} at rd_idx, registered
trace_cnt  out  $clog2(TRACE_DEPTH)+1  valid trace entries, saturates at TRACE_DEPTH
cycle_cnt  out  32  RUN cycles elapsed, saturates at 0xFFFFFFFF
busy  out  1  high in RUN
done  out  1  high in DONE, sticky
pass  out  1  valid when done=1
fail_code  out  2  0=none, 1=ACC_MISMATCH, 2=STALL, 3=TIMEOUT

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0, including rd_data, trace_cnt and cycle_cnt. Write pointer, stall counter and last_pc are 0. Reset asserted mid-RUN aborts the run immediately; no verdict is kept.
- clr=1 at a clock edge has the same effect as reset, applied synchronously. It takes priority over every other event.
- State machine:
  - IDLE -> RUN when en=1.
  - RUN -> DONE on exit, stall or timeout (see below).
  - DONE holds until clr or reset. In DONE, en is ignored.
- Entry cycle into RUN: write trace entry {io_pc, io_out}, load last_pc=io_pc, stall_cnt=0, cycle_cnt=1.
- Each subsequent RUN cycle:
  - cycle_cnt increments (saturating).
  - If io_pc != last_pc: write a trace entry, update last_pc, stall_cnt=0.
  - Otherwise stall_cnt increments.
- Terminating conditions, evaluated every RUN cycle. Priority is exit > stall > timeout:
  - io_exit=1: DONE. pass=(io_out==PASS_VAL). fail_code=0 on pass, 1 otherwise. The sample from the exit cycle is still traced if the PC changed.
  - stall_cnt reaches STALL_LIM-1 while io_pc is unchanged (STALL_LIM cycles at the same PC): DONE, pass=0, fail_code=2.
  - cycle_cnt reaches TIMEOUT_CYC: DONE, pass=0, fail_code=3.
- Verdict outputs update on the same edge as the DONE transition. busy=1 exactly while in RUN.
- Trace buffer:
  - Ring of TRACE_DEPTH entries. wr_ptr wraps modulo TRACE_DEPTH.
  - trace_cnt saturates at TRACE_DEPTH. On overflow the oldest entry is overwritten.
  - Physical read address = (wr_ptr - trace_cnt + rd_idx) mod TRACE_DEPTH.
  - rd_data is registered: 1-cycle latency from rd_idx.
  - rd_idx >= trace_cnt returns 0.
  - Reads are legal in every state. A simultaneous write and read to the same slot returns the old data.
- No writes occur in IDLE or DONE.

Optional Feature:
RUN_MON_PRINT_EN: when defined, simulation-only code runs:
- $display "pc=%h acc=%h" on every trace write.
- A single PASSED/FAILED line naming fail_code on entry to DONE.
- A final-block summary of cycle_cnt.
When undefined, no display code is elaborated and the RTL is purely synthesizable. Functional outputs are identical in both builds.

Test Plan:
- PC steps 0..5 one per cycle, then io_exit=1 with io_out=0 -> done=1, pass=1, fail_code=0, cycle_cnt=6, trace_cnt=6, rd_idx=0 gives pc=0.
- Same sequence but io_out=0x0012 at exit -> pass=0, fail_code=1.
- PC held at 0x20 for 64 cycles after start, STALL_LIM=64 -> fail_code=2 on the 64th cycle at 0x20; also assert io_exit on that same cycle -> fail_code=1/pass per io_out (exit wins).
- TIMEOUT_CYC=100, PC increments forever -> fail_code=3 with cycle_cnt=100. 40 distinct PCs with DEPTH=16 -> trace_cnt=16, rd_idx=0 returns the 25th PC.
- Drop rst mid-RUN at cycle 10 -> all outputs 0 asynchronously. Release, then pulse en -> fresh run with cycle_cnt restarting at 1.
- clr in DONE -> IDLE on next edge, done=0, trace_cnt=0. en asserted during DONE without clr -> no change.
